serial_byte_reader: RTL
=======================

# serial_byte_reader

Receive-side deserializer for the team's bit-serial byte bus. While `enable` is high it samples one bit per clock from `serial_bus`, LSB first, with `byte_start` marking bit 0 of each byte. Completed bytes go into a small FIFO and are presented on a valid/ready interface to downstream logic. Sticky flags report overrun and framing errors.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: bits per byte. Must be ≥ 2.
- `FIFO_DEPTH`, default 4: number of completed bytes buffered. Power of two, ≥ 2.

Ports:
- `clk`  in  1: single clock; all logic samples on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: bus is driven this cycle; one bit is sampled per cycle while high.
- `serial_bus`  in  1: serial data bit.
- `byte_start`  in  1: qualified by `enable`; the current bit is bit 0 of a new byte.
- `data_o`  out  DATA_WIDTH: FIFO head byte (bit 0 = first bit received).
- `data_valid`  out  1: `data_o` holds a valid byte.
- `data_ready`  in  1: consumer accepts `data_o` this cycle.
- `count`  out  clog2(DATA_WIDTH): index of the next bit expected.
- `overrun`  out  1: sticky; a completed byte was dropped because the FIFO was full.
- `framing_err`  out  1: sticky; `byte_start` arrived mid-byte.
- `clr_flags`  in  1: synchronous clear of `overrun` and `framing_err`.

## Operation
- Reset (async assert, sync release): state IDLE, `count`=0, shift register=0, FIFO empty. `data_valid`=0, `data_o`=0, `overrun`=0, `framing_err`=0.
- State IDLE:
  - `enable` && `byte_start`: load `serial_bus` into bit 0, `count`←1, go to SHIFT.
  - `enable` without `byte_start`: the bit is discarded and the state stays IDLE.
- State SHIFT:
  - `enable` && !`byte_start`: store `serial_bus` at bit `count`, then increment `count`.
  - When bit DATA_WIDTH-1 is stored: push the assembled byte, `count`←0, go to IDLE.
- `byte_start` in SHIFT: set `framing_err` and discard the partial byte. The current bit is taken as bit 0 of a new byte (`count`←1, stay in SHIFT).
- `enable` low: no sample is taken. State, `count` and the partial byte hold, so a byte may span gaps in `enable`.
- Shift register bits not yet written in the current byte are undefined. Only complete bytes are pushed.
- FIFO:
  - Push happens if not full, or if full with a pop in the same cycle. That combined case is accepted and does not set `overrun`.
  - Push to a full FIFO with no pop: the byte is dropped, `overrun`←1, and FIFO contents are unchanged.
  - Pop happens when `data_valid` && `data_ready`. `data_ready` while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit or an occupancy counter.
- `data_o` is the registered head entry. It must be stable while `data_valid` && !`data_ready`.
- `clr_flags` has priority over a same-cycle set, so the flag reads 0 next cycle. The error event is still handled as above.
- `rst_n` asserted mid-byte or with FIFO non-empty: all state returns to reset values immediately and buffered bytes are lost.

## Timing
- One bit per `enable` cycle, sampled at the rising edge.
- Latency: the byte completes at the edge that samples bit DATA_WIDTH-1. `data_valid` rises after that same edge, i.e. one cycle after the last bit is presented.
- Sustained rate: one byte every DATA_WIDTH enabled cycles with no gaps between bytes. If `byte_start` coincides with the edge after the last bit, it is accepted from IDLE.
- Pop: after the edge where `data_valid` && `data_ready`, the next entry (or `data_valid`=0) is visible.
- `count`, `overrun`, `framing_err` and `data_valid` are registered outputs with no combinational path from inputs.

## Test plan
- Reset, then send 0xA5 LSB-first (bits 1,0,1,0,0,1,0,1) with `byte_start` on bit 0 and `data_ready`=1 → `data_valid` for one cycle with `data_o`=0xA5 the cycle after bit 7, `count` returns to 0.
- Send 0x3C with `enable` dropped for 3 cycles after bit 4 → `count` holds at 5 during the gap, `data_o`=0x3C, no flags.
- `data_ready`=0, send 5 bytes 0x01..0x05 → FIFO holds 0x01..0x04, `overrun`=1 after byte 5. Draining yields 0x01, 0x02, 0x03, 0x04, then `data_valid`=0.
- FIFO full with `data_ready` pulsed on the completion edge of a new byte 0x77 → no overrun, 0x77 is last in order. Pulse `clr_flags` → `overrun`=0.
- `byte_start` at `count`=3, then a full byte 0xF0 → `framing_err`=1, only 0xF0 delivered.
- Assert `rst_n` low at `count`=4 with 2 bytes buffered → `data_valid`=0, `count`=0, flags 0. The next full byte is received correctly.

Source files
------------

// File: rtl/serial_byte_reader.sv
// Bit-serial receive deserializer: assembles LSB-first bytes framed by byte_start
// and buffers them in a small FIFO behind a valid/ready interface.
//
// state | meaning
// IDLE  | waiting for byte_start; enabled bits without it are discarded
// SHIFT | assembling a byte; count is the index of the next bit
module serial_byte_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          serial_bus,
  input  logic                          byte_start,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic [$clog2(DATA_WIDTH)-1:0] count,
  output logic                          overrun,
  output logic                          framing_err,
  input  logic                          clr_flags
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  load_first, store_bit, byte_done, frame_evt;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  full, empty, push, pop, drop;
  logic [DATA_WIDTH-1:0] push_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_first = 1'b0;
    store_bit  = 1'b0;
    byte_done  = 1'b0;
    frame_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && byte_start) begin
          load_first = 1'b1;
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (enable) begin
          if (byte_start) begin
            // restart: the partial byte is abandoned, this bit becomes bit 0
            frame_evt  = 1'b1;
            load_first = 1'b1;
          end else begin
            store_bit = 1'b1;
            if (count == LAST_BIT) begin
              byte_done = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      shreg <= '0;
    end else if (load_first) begin
      shreg[0] <= serial_bus;
      count    <= CW'(1);
    end else if (store_bit) begin
      shreg[count] <= serial_bus;
      count        <= byte_done ? '0 : count + CW'(1);
    end
  end

  // the final bit is merged straight into the pushed word
  assign push_data = {serial_bus, shreg[DATA_WIDTH-2:0]};

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && data_ready;
  assign push  = byte_done && (!full || pop);
  assign drop  = byte_done && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign data_valid = !empty;
  assign data_o     = data_valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else if (clr_flags) begin
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (drop)      overrun     <= 1'b1;
      if (frame_evt) framing_err <= 1'b1;
    end
  end

endmodule
